lc4_multiplier_seq: RTL

Iterative unsigned shift-add multiplier for the LC4 ALU, the multiply counterpart to the combinational divider. It computes a 2*WIDTH-bit product one multiplier bit per cycle, with a start/ready/valid handshake, so the pipeline can stall on MUL instead of carrying a deep combinational array. The low WIDTH bits form the LC4 MUL result; the high word is exposed for verification and for future MULH-style use.

---
 rtl/lc4_multiplier_seq.sv | 134 +++++++++++++
 1 files changed

// File: rtl/lc4_multiplier_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lc4_multiplier_seq
// Purpose  : Iterative unsigned shift-add multiplier for the LC4 ALU. Retires
//            one multiplier bit per cycle and produces a 2*WIDTH-bit product.
//            Uses a start/ready/valid handshake so the pipeline can stall on
//            MUL instead of carrying a deep combinational array.
// Ports    : clk            - system clock, rising edge
//            rst_n          - asynchronous active-low reset
//            i_start        - request, accepted when o_ready=1
//            i_multiplicand - operand A, captured on accept
//            i_multiplier   - operand B, captured on accept
//            o_ready        - high in IDLE and DONE
//            o_valid        - one-cycle pulse in DONE
//            o_product_lo   - product bits [WIDTH-1:0]   (LC4 MUL result)
//            o_product_hi   - product bits [2*WIDTH-1:WIDTH]
// Revision : 1.0 - initial release
// ============================================================================
module lc4_multiplier_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_multiplicand,
  input  logic [WIDTH-1:0] i_multiplier,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_product_lo,
  output logic [WIDTH-1:0] o_product_hi
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q,   state_d;
  logic [WIDTH-1:0]   acc_hi_q,  acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q,  acc_lo_d;
  logic [WIDTH-1:0]   mcand_q,   mcand_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [WIDTH-1:0]   prod_lo_q, prod_lo_d;
  logic [WIDTH-1:0]   prod_hi_q, prod_hi_d;

  // One shift-add step. The WIDTH+1-bit sum keeps the carry so that the
  // right shift moves it into acc_hi[WIDTH-1]; acc_lo shifts in sum[0] while
  // its LSB (the multiplier bit just consumed) falls off.
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;

  always_comb begin
    if (acc_lo_q[0]) begin
      sum = {1'b0, acc_hi_q} + {1'b0, mcand_q};
    end else begin
      sum = {1'b0, acc_hi_q};
    end
    step_hi = sum[WIDTH:1];
    step_lo = {sum[0], acc_lo_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    prod_lo_d = prod_lo_q;
    prod_hi_d = prod_hi_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          // Accept from DONE goes straight to RUN, giving back-to-back
          // throughput of one result every WIDTH+1 cycles.
          mcand_d  = i_multiplicand;
          acc_hi_d = '0;
          acc_lo_d = i_multiplier;
          cnt_d    = CNT_W'(WIDTH);
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Product registers load only here, so they hold across a
          // back-to-back restart that reloads the accumulator.
          prod_hi_d = step_hi;
          prod_lo_d = step_lo;
          state_d   = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      prod_lo_q <= '0;
      prod_hi_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      prod_lo_q <= prod_lo_d;
      prod_hi_q <= prod_hi_d;
    end
  end

  assign o_ready      = (state_q != ST_RUN);
  assign o_valid      = (state_q == ST_DONE);
  assign o_product_lo = prod_lo_q;
  assign o_product_hi = prod_hi_q;

endmodule
`default_nettype wire
